// File: rtl/dist_mem_pkg.sv
// Shared types and constants for the distributed-RAM responder.
// Covers the fill pattern selection, init FSM state encoding and a clog2 helper.
package dist_mem_pkg;

    typedef enum logic [1:0] {
        INIT_NONE     = 2'd0,
        INIT_ALL_ZERO = 2'd1,
        INIT_ALL_ONE  = 2'd2
    } init_mode_e;

    localparam logic INIT_ZERO_BIT = 1'b0;
    localparam logic INIT_ONE_BIT  = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/dist_mem_init_seq.sv
// Post-reset init sequencer: walks every address once, driving the fill pattern,
// then parks in READY until the next reset.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | one cycle after reset; picks FILL or READY from MODE
//  ST_FILL  | writes fill_data to fill_addr, one word per cycle, busy=1
//  ST_READY | array owned by the port; held until reset
module dist_mem_init_seq
    import dist_mem_pkg::*;
#(
    parameter int         ADDR_DEPTH = 128,
    parameter int         DATA_WIDTH = 8,
    parameter int         ADDR_WIDTH = 7,
    parameter init_mode_e MODE       = INIT_NONE
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    output logic                  fill_we,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  busy,
    output logic                  ready
);

    // One extra counter bit so a power-of-two depth reaches its last address cleanly.
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(ADDR_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [ADDR_WIDTH:0] cnt;
    logic [ADDR_WIDTH:0] cnt_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                cnt_nxt   = '0;
                state_nxt = (MODE == INIT_NONE) ? ST_READY : ST_FILL;
            end
            ST_FILL: begin
                if (cnt == LAST_ADDR) state_nxt = ST_READY;
                else                  cnt_nxt   = cnt + CNT_ONE;
            end
            ST_READY: state_nxt = ST_READY;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign fill_we   = (state == ST_FILL);
    assign busy      = (state == ST_FILL);
    assign ready     = (state == ST_READY);
    assign fill_addr = cnt[ADDR_WIDTH-1:0];
    assign fill_data = {DATA_WIDTH{(MODE == INIT_ALL_ONE) ? INIT_ONE_BIT : INIT_ZERO_BIT}};

endmodule

// File: rtl/dist_mem_responder.sv
// Single-clock distributed-RAM responder with post-reset fill and selectable read latency.
// Optional feature macro: DIST_MEM_PARITY_EN (per-word even parity, injection and check).
module dist_mem_responder
    import dist_mem_pkg::*;
#(
    parameter int    ADDR_DEPTH = 128,
    parameter int    DATA_WIDTH = 8,
    parameter int    ADDR_WIDTH = clog2(ADDR_DEPTH),
    parameter string REGMODE    = "reg",
    parameter string INIT_MODE  = "none"
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  wr_clk_en_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_clk_en_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] mem_rdout_o,
`ifdef DIST_MEM_PARITY_EN
    input  logic                  parity_inj_i,
    output logic                  parity_err_o,
`endif
    output logic                  init_busy_o
);

`ifdef DIST_MEM_PARITY_EN
    localparam int MEM_WIDTH = DATA_WIDTH + 1;
`else
    localparam int MEM_WIDTH = DATA_WIDTH;
`endif

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(ADDR_DEPTH);
    localparam init_mode_e INIT_SEL =
        (INIT_MODE == "all_zero") ? INIT_ALL_ZERO :
        (INIT_MODE == "all_one")  ? INIT_ALL_ONE  : INIT_NONE;

    logic [MEM_WIDTH-1:0]  mem [ADDR_DEPTH];

    logic                  fill_we;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic [DATA_WIDTH-1:0] fill_data;
    logic                  ready;

    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [MEM_WIDTH-1:0]  wr_word;
    logic [MEM_WIDTH-1:0]  fill_word;
    logic [MEM_WIDTH-1:0]  rd_raw;
    logic [DATA_WIDTH-1:0] rd_word;

    dist_mem_init_seq #(
        .ADDR_DEPTH (ADDR_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MODE       (INIT_SEL)
    ) u_init_seq (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .fill_we   (fill_we),
        .fill_addr (fill_addr),
        .fill_data (fill_data),
        .busy      (init_busy_o),
        .ready     (ready)
    );

    assign wr_in_range = ({1'b0, wr_addr_i} < DEPTH_W);
    assign rd_in_range = ({1'b0, rd_addr_i} < DEPTH_W);
    assign wr_acc      = ready && wr_clk_en_i && wr_en_i && wr_in_range;
    assign rd_acc      = ready && rd_clk_en_i && rd_en_i;

`ifdef DIST_MEM_PARITY_EN
    assign wr_word   = {(^wr_data_i) ^ parity_inj_i, wr_data_i};
    assign fill_word = {^fill_data, fill_data};
`else
    assign wr_word   = wr_data_i;
    assign fill_word = fill_data;
`endif

    // Fill and port writes never overlap (port needs READY), fill still takes priority.
    always_ff @(posedge clk_i) begin
        if (fill_we)     mem[fill_addr] <= fill_word;
        else if (wr_acc) mem[wr_addr_i] <= wr_word;
    end

    assign rd_raw      = rd_in_range ? mem[rd_addr_i] : '0;
    assign rd_word     = rd_raw[DATA_WIDTH-1:0];
    assign mem_rdout_o = rd_word;

    if (REGMODE == "reg") begin : g_rd_reg
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;
`ifdef DIST_MEM_PARITY_EN
        logic                  perr_q;
`endif

        // rd_raw is sampled before this edge's write lands, so a colliding read sees the old word.
        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
`ifdef DIST_MEM_PARITY_EN
                perr_q     <= 1'b0;
`endif
            end else if (rd_acc) begin
                rd_data_q  <= rd_word;
                rd_valid_q <= 1'b1;
`ifdef DIST_MEM_PARITY_EN
                perr_q     <= ^rd_raw;
`endif
            end else begin
                rd_valid_q <= 1'b0;
`ifdef DIST_MEM_PARITY_EN
                perr_q     <= 1'b0;
`endif
            end
        end

        assign rd_data_o  = rd_data_q;
        assign rd_valid_o = rd_valid_q;
`ifdef DIST_MEM_PARITY_EN
        assign parity_err_o = perr_q;
`endif
    end else begin : g_rd_comb
        assign rd_data_o  = ready ? rd_word : '0;
        assign rd_valid_o = rd_acc;
`ifdef DIST_MEM_PARITY_EN
        assign parity_err_o = rd_acc & (^rd_raw);
`endif
    end

endmodule
